// File: rtl/bsg_manycore_crossbar_link_endpoint.sv
// Credit-managed endpoint between a manycore ready/and link and one crossbar port.
// Egress flattens x/y into a port index; ingress buffers and expands it back.
module bsg_manycore_crossbar_link_endpoint #(
    parameter int width_p           = 16,
    parameter int x_cord_width_p    = 3,
    parameter int y_cord_width_p    = 2,
    parameter int num_in_x_p        = 4,
    parameter int num_in_y_p        = 2,
    parameter int credits_p         = 4,
    parameter int fifo_els_p        = 4,
    parameter int lg_num_in_lp      = ((num_in_x_p * num_in_y_p) == 1) ? 1
                                      : $clog2(num_in_x_p * num_in_y_p),
    parameter int xbar_width_lp     = width_p - x_cord_width_p - y_cord_width_p
                                      + lg_num_in_lp,
    parameter int link_sif_width_lp = width_p + 2
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    output logic [link_sif_width_lp-1:0] link_sif_o,
    output logic                         xbar_v_o,
    output logic [xbar_width_lp-1:0]     xbar_data_o,
    input  logic                         xbar_credit_i,
    input  logic                         xbar_v_i,
    input  logic [xbar_width_lp-1:0]     xbar_data_i,
    output logic                         xbar_credit_o,
    output logic [2:0]                   err_o
);

    localparam int cord_w_lp   = x_cord_width_p + y_cord_width_p;
    localparam int credit_w_lp = $clog2(credits_p + 1);
    localparam int ptr_w_lp    = (fifo_els_p == 1) ? 1 : $clog2(fifo_els_p);
    localparam int cnt_w_lp    = $clog2(fifo_els_p + 1);

    logic                 in_v;
    logic                 in_rdy;
    logic [width_p-1:0]   in_data;

    assign {in_v, in_rdy, in_data} = link_sif_i;

    logic [x_cord_width_p-1:0]    eg_x;
    logic [y_cord_width_p-1:0]    eg_y;
    logic [width_p-cord_w_lp-1:0] eg_payload;
    logic [lg_num_in_lp-1:0]      eg_idx;
    logic                         eg_oob;

    assign eg_x       = in_data[x_cord_width_p-1:0];
    assign eg_y       = in_data[cord_w_lp-1:x_cord_width_p];
    assign eg_payload = in_data[width_p-1:cord_w_lp];
    assign eg_idx     = lg_num_in_lp'(32'(eg_x) + 32'(eg_y) * 32'(num_in_x_p));
    assign eg_oob     = (32'(eg_x) >= 32'(num_in_x_p))
                      || (32'(eg_y) >= 32'(num_in_y_p));

    logic [credit_w_lp-1:0] credit_q, credit_d;
    logic [2:0]             err_q, err_d;
    logic                   have_credit;
    logic                   credit_full;
    logic                   send;

    assign have_credit = (credit_q != '0);
    assign credit_full = (credit_q == credit_w_lp'(credits_p));
    // Reset gates the send so the crossbar never sees a packet during reset.
    assign send        = in_v & have_credit & reset_n_i;

    assign xbar_v_o    = send;
    assign xbar_data_o = {eg_payload, eg_idx};

    logic [xbar_width_lp-1:0] mem_q [fifo_els_p];
    logic [ptr_w_lp-1:0]      rptr_q, rptr_d;
    logic [ptr_w_lp-1:0]      wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
    logic                     cred_pulse_q;
    logic                     empty;
    logic                     full;
    logic                     deq;
    logic                     enq;
    logic                     drop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == cnt_w_lp'(fifo_els_p));
    assign deq   = ~empty & in_rdy;
    assign enq   = xbar_v_i & (~full | deq);
    assign drop  = xbar_v_i & full & ~deq;

    function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        cnt_d    = cnt_q;
        if (send && !xbar_credit_i) begin
            credit_d = credit_q - credit_w_lp'(1);
        end else if (!send && xbar_credit_i) begin
            if (credit_full) err_d[0] = 1'b1;
            else             credit_d = credit_q + credit_w_lp'(1);
        end
        if (send && eg_oob) err_d[2] = 1'b1;
        if (drop)           err_d[1] = 1'b1;
        if (enq) wptr_d = ptr_next(wptr_q);
        if (deq) rptr_d = ptr_next(rptr_q);
        if (enq && !deq)      cnt_d = cnt_q + cnt_w_lp'(1);
        else if (deq && !enq) cnt_d = cnt_q - cnt_w_lp'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credit_q     <= credit_w_lp'(credits_p);
            err_q        <= '0;
            rptr_q       <= '0;
            wptr_q       <= '0;
            cnt_q        <= '0;
            cred_pulse_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            err_q        <= err_d;
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            cred_pulse_q <= deq;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= xbar_data_i;
    end

    logic [xbar_width_lp-1:0]            head;
    logic [lg_num_in_lp-1:0]             in_idx;
    logic [xbar_width_lp-lg_num_in_lp-1:0] in_payload;
    logic [y_cord_width_p-1:0]           in_y;
    logic [x_cord_width_p-1:0]           in_x;

    assign head       = mem_q[rptr_q];
    assign in_idx     = head[lg_num_in_lp-1:0];
    assign in_payload = head[xbar_width_lp-1:lg_num_in_lp];
    assign in_y       = y_cord_width_p'(32'(in_idx) / 32'(num_in_x_p));
    assign in_x       = x_cord_width_p'(32'(in_idx) % 32'(num_in_x_p));

    assign link_sif_o    = {~empty, have_credit, in_payload, in_y, in_x};
    assign xbar_credit_o = cred_pulse_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_bsg_manycore_crossbar_link_endpoint.sv
// Randomized self-checking bench for the crossbar link endpoint,
// with a queue/counter reference model of the link and crossbar.
module tb_bsg_manycore_crossbar_link_endpoint;

    localparam int WP = 16, XW = 3, YW = 2, NX = 4, NY = 2;
    localparam int CR = 4, FE = 4, LG = 3, XBW = 14, LSW = 18;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            lv, lrdy;
    logic [WP-1:0]   ldata;
    logic [LSW-1:0]  link_i, link_o;
    logic            xv_o;
    logic [XBW-1:0]  xd_o;
    logic            xcred_i, xv_i, xcred_o;
    logic [XBW-1:0]  xd_i;
    logic [2:0]      err;
    logic            lo_v, lo_rdy;
    logic [WP-1:0]   lo_data;

    int errors = 0;
    int checks = 0;

    assign link_i  = {lv, lrdy, ldata};
    assign lo_v    = link_o[LSW-1];
    assign lo_rdy  = link_o[LSW-2];
    assign lo_data = link_o[WP-1:0];

    bsg_manycore_crossbar_link_endpoint #(
        .width_p(WP), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .num_in_x_p(NX), .num_in_y_p(NY), .credits_p(CR), .fifo_els_p(FE)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .link_sif_i(link_i), .link_sif_o(link_o),
        .xbar_v_o(xv_o), .xbar_data_o(xd_o), .xbar_credit_i(xcred_i),
        .xbar_v_i(xv_i), .xbar_data_i(xd_i), .xbar_credit_o(xcred_o),
        .err_o(err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [XBW-1:0] enc(input logic [WP-1:0] d);
        int x, y, idx;
        x = int'(d[2:0]);
        y = int'(d[4:3]);
        idx = (x + y * NX) % (1 << LG);
        return {d[WP-1:5], 3'(idx)};
    endfunction

    function automatic logic [WP-1:0] dec(input logic [XBW-1:0] p);
        int idx, x, y;
        idx = int'(p[2:0]);
        y = (idx / NX) % (1 << YW);
        x = (idx % NX) % (1 << XW);
        return {p[XBW-1:3], 2'(y), 3'(x)};
    endfunction

    function automatic logic [WP-1:0] mk(input int x, input int y);
        return {11'($urandom), 2'(y), 3'(x)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        lv = 0; lrdy = 0; ldata = '0;
        xcred_i = 0; xv_i = 0; xd_i = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        lv = 1; lrdy = 1; ldata = mk(1, 1);
        xcred_i = 0; xv_i = 0; xd_i = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (lo_v !== 1'b0) begin errors++; $display("FAIL rst_link_v: got %b want 0", lo_v); end
        checks++; if (lo_rdy !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", lo_rdy); end
        checks++; if (xv_o !== 1'b0) begin errors++; $display("FAIL rst_xbar_v: got %b want 0", xv_o); end
        checks++; if (xcred_o !== 1'b0) begin errors++; $display("FAIL rst_credit_o: got %b want 0", xcred_o); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rst_err: got %b want 000", err); end
        reset_n = 1'b1;
        #1;
        checks++; if (xv_o !== 1'b1) begin errors++; $display("FAIL post_rst_xbar_v: got %b want 1", xv_o); end
        checks++; if (lo_v !== 1'b0) begin errors++; $display("FAIL post_rst_link_v: got %b want 0", lo_v); end
        lv = 0;
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        lv = 1; ldata = mk(5, 0);
        tick();
        lv = 0;
        xv_i = 1; xd_i = 14'($urandom);
        tick();
        xd_i = 14'($urandom);
        tick();
        xv_i = 0; lrdy = 1; lv = 1; ldata = mk(2, 1);
        tick();
        checks++; if (xcred_o !== 1'b1) begin errors++; $display("FAIL arst_pre_credit: got %b want 1", xcred_o); end
        checks++; if (err !== 3'b100) begin errors++; $display("FAIL arst_pre_err: got %b want 100", err); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (lo_v !== 1'b0) begin errors++; $display("FAIL arst_link_v: got %b want 0", lo_v); end
        checks++; if (xv_o !== 1'b0) begin errors++; $display("FAIL arst_xbar_v: got %b want 0", xv_o); end
        checks++; if (xcred_o !== 1'b0) begin errors++; $display("FAIL arst_credit_o: got %b want 0", xcred_o); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL arst_err: got %b want 000", err); end
        checks++; if (lo_rdy !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", lo_rdy); end
        lv = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        checks++; if (lo_v !== 1'b0) begin errors++; $display("FAIL arst_discard_v: got %b want 0", lo_v); end
        checks++; if (xcred_o !== 1'b0) begin errors++; $display("FAIL arst_no_credit: got %b want 0", xcred_o); end
        lrdy = 0;
    endtask

    task automatic test_egress_encode();
        logic [XBW-1:0] want;
        apply_reset();
        lv = 1;
        ldata = {11'hAB, 2'd1, 3'd3};
        want = {11'hAB, 3'd7};
        #1;
        checks++; if (xv_o !== 1'b1) begin errors++; $display("FAIL enc_v: got %b want 1", xv_o); end
        checks++; if (xd_o !== want) begin errors++; $display("FAIL enc_x3y1: got %h want %h", xd_o, want); end
        tick();
        for (int i = 0; i < 4; i++) begin
            ldata = mk($urandom_range(0, NX - 1), $urandom_range(0, NY - 1));
            xcred_i = 1;
            #1;
            checks++; if (xd_o !== enc(ldata)) begin errors++; $display("FAIL enc_rand: got %h want %h", xd_o, enc(ldata)); end
            tick();
        end
        xcred_i = 0;
        ldata = mk(5, 0);
        #1;
        checks++; if (xd_o !== enc(ldata)) begin errors++; $display("FAIL enc_x5: got %h want %h", xd_o, enc(ldata)); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL enc_err_early: got %b want 000", err); end
        tick();
        ldata = mk(5, 1);
        #1;
        checks++; if (xd_o[2:0] !== 3'd1) begin errors++; $display("FAIL enc_trunc: got %0d want 1", xd_o[2:0]); end
        tick();
        lv = 0;
        tick();
        tick();
        checks++; if (err !== 3'b100) begin errors++; $display("FAIL enc_oob_sticky: got %b want 100", err); end
    endtask

    task automatic test_credit_exhaustion();
        apply_reset();
        lv = 1; ldata = mk(1, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (xv_o !== (i < 4)) begin errors++; $display("FAIL cred_send%0d: got %b want %b", i, xv_o, i < 4); end
            checks++; if (lo_rdy !== (i < 4)) begin errors++; $display("FAIL cred_rdy%0d: got %b want %b", i, lo_rdy, i < 4); end
            tick();
        end
        xcred_i = 1;
        #1;
        checks++; if (xv_o !== 1'b0) begin errors++; $display("FAIL cred_zero_v: got %b want 0", xv_o); end
        tick();
        xcred_i = 0;
        #1;
        checks++; if (xv_o !== 1'b1) begin errors++; $display("FAIL cred_one_more: got %b want 1", xv_o); end
        tick();
        #1;
        checks++; if (xv_o !== 1'b0) begin errors++; $display("FAIL cred_only_one: got %b want 0", xv_o); end
        lv = 0; xcred_i = 1;
        tick();
        lv = 1;
        tick();
        lv = 0; xcred_i = 0;
        #1;
        checks++; if (lo_rdy !== 1'b1) begin errors++; $display("FAIL cred_same_cycle: got %b want 1", lo_rdy); end
        lv = 1;
        tick();
        lv = 0;
        #1;
        checks++; if (lo_rdy !== 1'b0) begin errors++; $display("FAIL cred_back_zero: got %b want 0", lo_rdy); end
        xcred_i = 1;
        repeat (4) tick();
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL cred_no_ovf: got %b want 000", err); end
        tick();
        xcred_i = 0;
        #1;
        checks++; if (err !== 3'b001) begin errors++; $display("FAIL cred_ovf: got %b want 001", err); end
        lv = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (xv_o !== (i < 4)) begin errors++; $display("FAIL cred_hold%0d: got %b want %b", i, xv_o, i < 4); end
            tick();
        end
        lv = 0;
    endtask

    task automatic test_ingress_decode();
        logic [XBW-1:0] p;
        logic [WP-1:0]  want;
        apply_reset();
        lrdy = 0;
        p = {11'($urandom), 3'd6};
        want = {p[XBW-1:3], 2'd1, 3'd2};
        xv_i = 1; xd_i = p;
        #1;
        checks++; if (lo_v !== 1'b0) begin errors++; $display("FAIL dec_early_v: got %b want 0", lo_v); end
        tick();
        xv_i = 0;
        #1;
        checks++; if (lo_v !== 1'b1) begin errors++; $display("FAIL dec_v: got %b want 1", lo_v); end
        checks++; if (lo_data !== want) begin errors++; $display("FAIL dec_idx6: got %h want %h", lo_data, want); end
        checks++; if (xcred_o !== 1'b0) begin errors++; $display("FAIL dec_no_credit: got %b want 0", xcred_o); end
        lrdy = 1;
        tick();
        #1;
        checks++; if (xcred_o !== 1'b1) begin errors++; $display("FAIL dec_credit: got %b want 1", xcred_o); end
        checks++; if (lo_v !== 1'b0) begin errors++; $display("FAIL dec_empty: got %b want 0", lo_v); end
        tick();
        checks++; if (xcred_o !== 1'b0) begin errors++; $display("FAIL dec_credit_once: got %b want 0", xcred_o); end
        lrdy = 0;
    endtask

    task automatic test_back_to_back();
        logic [WP-1:0] q[$];
        logic prev_deq, deq;
        apply_reset();
        lrdy = 1;
        prev_deq = 0;
        for (int i = 0; i < 11; i++) begin
            xv_i = (i < 8);
            xd_i = {11'($urandom), 3'(i)};
            #1;
            checks++; if (lo_v !== (q.size() > 0)) begin errors++; $display("FAIL b2b_v%0d: got %b want %b", i, lo_v, q.size() > 0); end
            checks++; if (xcred_o !== prev_deq) begin errors++; $display("FAIL b2b_credit%0d: got %b want %b", i, xcred_o, prev_deq); end
            deq = (q.size() > 0);
            if (deq) begin
                checks++; if (lo_data !== q[0]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, lo_data, q[0]); end
                void'(q.pop_front());
            end
            if (xv_i) q.push_back(dec(xd_i));
            prev_deq = deq;
            tick();
        end
        xv_i = 0; lrdy = 0;
    endtask

    task automatic test_fifo_backpressure();
        logic [WP-1:0] q[$];
        apply_reset();
        lrdy = 0;
        for (int i = 0; i < 4; i++) begin
            xv_i = 1; xd_i = 14'($urandom);
            q.push_back(dec(xd_i));
            tick();
        end
        xd_i = 14'($urandom);
        #1;
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL bp_err_early: got %b want 000", err); end
        tick();
        xv_i = 0;
        #1;
        checks++; if (err !== 3'b010) begin errors++; $display("FAIL bp_drop_err: got %b want 010", err); end
        checks++; if (lo_data !== q[0]) begin errors++; $display("FAIL bp_head: got %h want %h", lo_data, q[0]); end
        xv_i = 1; xd_i = 14'($urandom); lrdy = 1;
        void'(q.pop_front());
        q.push_back(dec(xd_i));
        tick();
        xv_i = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (lo_v !== (q.size() > 0)) begin errors++; $display("FAIL bp_v%0d: got %b want %b", i, lo_v, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if (lo_data !== q[0]) begin errors++; $display("FAIL bp_order%0d: got %h want %h", i, lo_data, q[0]); end
                void'(q.pop_front());
            end
            tick();
        end
        lrdy = 0;
    endtask

    task automatic test_streaming();
        logic [WP-1:0] inq[$];
        int mcred, xbuf, xcr, deq_cnt, pulse_cnt;
        logic prev_deq, deq, send;
        apply_reset();
        mcred = CR; xbuf = 0; xcr = FE;
        deq_cnt = 0; pulse_cnt = 0; prev_deq = 0;
        for (int i = 0; i < 1012; i++) begin
            if (i < 1000) begin
                lv = 1'($urandom_range(0, 1));
                ldata = mk($urandom_range(0, NX - 1), $urandom_range(0, NY - 1));
                lrdy = 1'($urandom_range(0, 1));
                xcred_i = (xbuf > 0) && ($urandom_range(0, 1) == 1);
                xv_i = (xcr > 0) && ($urandom_range(0, 1) == 1);
                xd_i = 14'($urandom);
            end else begin
                lv = 0; lrdy = 1; xv_i = 0;
                xcred_i = (xbuf > 0);
            end
            if (xcred_i) xbuf--;
            #1;
            send = lv && (mcred > 0);
            checks++; if (xv_o !== send) begin errors++; $display("FAIL st_xv%0d: got %b want %b", i, xv_o, send); end
            checks++; if (lo_rdy !== (mcred > 0)) begin errors++; $display("FAIL st_rdy%0d: got %b want %b", i, lo_rdy, mcred > 0); end
            if (send) begin
                checks++; if (xd_o !== enc(ldata)) begin errors++; $display("FAIL st_xd%0d: got %h want %h", i, xd_o, enc(ldata)); end
                xbuf++;
            end
            checks++; if (xbuf > CR) begin errors++; $display("FAIL st_xbuf%0d: got %0d want <=%0d", i, xbuf, CR); end
            checks++; if (lo_v !== (inq.size() > 0)) begin errors++; $display("FAIL st_lv%0d: got %b want %b", i, lo_v, inq.size() > 0); end
            deq = (inq.size() > 0) && lrdy;
            if (deq) begin
                checks++; if (lo_data !== inq[0]) begin errors++; $display("FAIL st_ld%0d: got %h want %h", i, lo_data, inq[0]); end
                void'(inq.pop_front());
                deq_cnt++;
            end
            checks++; if (xcred_o !== prev_deq) begin errors++; $display("FAIL st_co%0d: got %b want %b", i, xcred_o, prev_deq); end
            if (xcred_o) begin pulse_cnt++; xcr++; end
            if (xv_i) begin inq.push_back(dec(xd_i)); xcr--; end
            mcred = mcred + (xcred_i ? 1 : 0) - (send ? 1 : 0);
            prev_deq = deq;
            tick();
        end
        checks++; if (lo_v !== 1'b0) begin errors++; $display("FAIL st_drained: got %b want 0", lo_v); end
        checks++; if (pulse_cnt !== deq_cnt) begin errors++; $display("FAIL st_credits: got %0d want %0d", pulse_cnt, deq_cnt); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL st_err: got %b want 000", err); end
        lrdy = 0;
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_egress_encode();
        test_credit_exhaustion();
        test_ingress_decode();
        test_back_to_back();
        test_fifo_backpressure();
        test_streaming();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_crossbar_link_endpoint.md
# bsg_manycore_crossbar_link_endpoint

- Credit-managed endpoint between one manycore ready/and link and one crossbar port.
- **Egress (link → crossbar):** re-encodes the packet's x/y destination into a flat crossbar port index, and gates sending with a credit counter sized to the crossbar's input buffer.
- **Ingress (crossbar → link):** buffers crossbar packets in a small FIFO, decodes the flat index back to x/y, presents the packets on the link, and returns one credit per dequeue.
- Instantiated once per tile-side port of the crossbar network in the testbench.

## Interface

Parameters:
- width_p, none: link packet width; bits [x_cord_width_p-1:0] are the x coordinate, the next y_cord_width_p bits are the y coordinate.
- x_cord_width_p, none: x coordinate width.
- y_cord_width_p, none: y coordinate width.
- num_in_x_p, none: crossbar grid columns.
- num_in_y_p, none: crossbar grid rows.
- credits_p, 4: egress credits; equals the crossbar input buffer depth.
- fifo_els_p, 4: ingress FIFO depth; equals the credits the crossbar holds toward this port.
- lg_num_in_lp, derived: BSG_SAFE_CLOG2(num_in_x_p*num_in_y_p).
- xbar_width_lp, derived: width_p-x_cord_width_p-y_cord_width_p+lg_num_in_lp.
- link_sif_width_lp, derived: bsg_ready_and_link_sif_width(width_p).

Ports:
- clk_i, input, 1: clock. One clock domain.
- reset_n_i, input, 1: reset; asynchronous, active-low.
- link_sif_i, input, link_sif_width_lp: link from the tile, packed as {v, ready_and_rev, data}.
- link_sif_o, output, link_sif_width_lp: link to the tile, same packing.
- xbar_v_o, output, 1: egress packet valid.
- xbar_data_o, output, xbar_width_lp: egress packet, {payload, port_idx}.
- xbar_credit_i, input, 1: one-cycle pulse; one egress credit returned.
- xbar_v_i, input, 1: ingress packet valid.
- xbar_data_i, input, xbar_width_lp: ingress packet, {payload, port_idx}.
- xbar_credit_o, output, 1: one-cycle pulse; one ingress credit returned.
- err_o, output, 3: sticky error flags.
  - [0]: egress credit overflow.
  - [1]: ingress FIFO overflow.
  - [2]: egress coordinate out of range.

## Operation

Egress path:
- credit_r has width clog2(credits_p+1).
- link_sif_o.ready_and_rev = (credit_r != 0).
- xbar_v_o = link_sif_i.v & (credit_r != 0). The path is combinational and has zero latency.
- port_idx = lg_num_in_lp-bit truncation of x + y*num_in_x_p.
- payload = data[width_p-1 : x_cord_width_p+y_cord_width_p].
- Credit counter update:
  - Send only: credit_r - 1.
  - xbar_credit_i only: credit_r + 1.
  - Both in the same cycle: credit_r unchanged.
- xbar_credit_i arriving while credit_r == credits_p (and no send that cycle): credit_r holds at credits_p and err_o[0] sets.
- A send with x >= num_in_x_p or y >= num_in_y_p still proceeds with the truncated index, and err_o[2] sets.

Ingress path:
- FIFO of fifo_els_p entries, each xbar_width_lp bits, with wrapping read/write pointers and an occupancy count.
- Enqueue on xbar_v_i.
- xbar_v_i while full with no dequeue that cycle: the packet is dropped, err_o[1] sets, and FIFO state is unchanged.
- xbar_v_i while full with a dequeue in the same cycle: the packet is accepted and occupancy stays full.
- link_sif_o.v = FIFO not empty.
- link_sif_o.data = {payload, y, x}, where:
  - y = y_cord_width_p-bit truncation of idx / num_in_x_p;
  - x = x_cord_width_p-bit truncation of idx % num_in_x_p.
- Dequeue when link_sif_o.v & link_sif_i.ready_and_rev.
- xbar_credit_o is a registered pulse: high for exactly one cycle, the cycle after each dequeue.

Errors:
- err_o bits are sticky and clear only on reset.

## Timing

Reset:
- Reset is asynchronous: assertion of reset_n_i low clears state immediately, without waiting for a clock edge.
- Values while reset_n_i is low: credit_r = credits_p, FIFO empty with pointers 0, link_sif_o.v = 0, xbar_v_o = 0, xbar_credit_o = 0, err_o = 0.
- Reset mid-operation discards in-flight FIFO contents and any pending credit pulse. No credits are returned for discarded packets.

Latency:
- Egress: 0 cycles from link to crossbar.
- Ingress: a packet enqueued at edge N is visible on link_sif_o at cycle N+1.
- Credit return: a dequeue at edge N produces xbar_credit_o high in cycle N+1.
- Sustained throughput is 1 packet/cycle in each direction.

Egress throughput is limited by credits:
- With credits_p = 4 and credit round trip R, steady-state rate is min(1, 4/R).

Back-to-back dequeues produce back-to-back credit pulses, one per cycle.

## Test plan

- **Reset values:** hold reset_n_i low, then release.
  - Outputs follow the reset values above.
  - link_sif_o.ready_and_rev = 1.
  - Drop reset_n_i low mid-packet between clock edges → outputs clear immediately, without waiting for a clock edge.
- **Egress encode:** num_in_x_p=4, num_in_y_p=2, send a packet with x=3, y=1, payload 0xAB.
  - xbar_data_o = {0xAB, 3'd7}, same cycle.
  - x=5 → err_o[2] sets and stays set.
- **Credit exhaustion:** send 5 packets with no xbar_credit_i.
  - 4 sent, then ready_and_rev = 0.
  - Pulse xbar_credit_i once → exactly one more send.
  - Send and credit in the same cycle → count unchanged.
  - Extra credit at full → err_o[0] sets.
- **Ingress decode:** xbar_v_i with idx=6, num_in_x_p=4.
  - Next cycle: link_sif_o.v = 1 with y=1, x=2.
  - Dequeue → xbar_credit_o high for 1 cycle, the following cycle.
- **FIFO backpressure:** ready_and_rev = 0, enqueue 4 packets → full.
  - A 5th packet alone → dropped, err_o[1] set.
  - A 5th packet with a simultaneous dequeue → accepted.
  - Order is preserved across pointer wrap.
- **Streaming:** random valid/ready on both sides for 1000 cycles with a credit-correct crossbar model.
  - No loss or reorder.
  - Credits returned equal packets dequeued.
  - err_o = 0.
